soat_mc_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle SOAT CPU. It executes the same 16-bit instruction format through a fetch/decode/execute/memory/write-back state machine, with a configurable datapath and address width. It adds handshaked instruction and data memory ports, an iterative multiplier feeding HI/LO, MFHI/MFLO written to `rd`, JR, and HALT/illegal-opcode detection. It is the top-level core instantiated by the SoC wrapper.

---
 rtl/soat_pkg.sv | 60 ++++++
 rtl/soat_mc_core_if.sv | 30 +++
 rtl/soat_regfile.sv | 29 ++
 rtl/soat_mc_core.sv | 194 +++++++++++++++++++
 tb/tb_soat_mc_core.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soat_pkg.sv
// soat_pkg: shared opcode/funct codes, FSM state type and instruction field positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package soat_pkg;

   // Opcodes
   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ADDI  = 4'h1;
   localparam logic [3:0] OP_LW    = 4'h2;
   localparam logic [3:0] OP_SW    = 4'h3;
   localparam logic [3:0] OP_BEQ   = 4'h4;
   localparam logic [3:0] OP_BNE   = 4'h5;
   localparam logic [3:0] OP_J     = 4'h6;
   localparam logic [3:0] OP_JAL   = 4'h7;
   localparam logic [3:0] OP_JR    = 4'h8;
   localparam logic [3:0] OP_HALT  = 4'hF;

   // R-type funct codes
   localparam logic [2:0] FN_ADD  = 3'b000;
   localparam logic [2:0] FN_SUB  = 3'b001;
   localparam logic [2:0] FN_AND  = 3'b010;
   localparam logic [2:0] FN_OR   = 3'b011;
   localparam logic [2:0] FN_MFHI = 3'b100;
   localparam logic [2:0] FN_MFLO = 3'b101;
   localparam logic [2:0] FN_MULT = 3'b110;
   localparam logic [2:0] FN_SLT  = 3'b111;

   // Instruction field positions
   localparam int OP_MSB = 15;
   localparam int OP_LSB = 12;
   localparam int RS_MSB = 11;
   localparam int RS_LSB = 9;
   localparam int RT_MSB = 8;
   localparam int RT_LSB = 6;
   localparam int RD_MSB = 5;
   localparam int RD_LSB = 3;
   localparam int FN_MSB = 2;
   localparam int FN_LSB = 0;
   localparam int IMM_MSB = 5;
   localparam int TGT_MSB = 11;

   localparam logic [2:0] LINK_REG = 3'd7;

   typedef enum logic [2:0] {
      S_RST,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_MULT,
      S_HALT
   } state_t;

   // Opcodes 0x9..0xE have no meaning and stop the core.
   function automatic logic is_illegal(input logic [3:0] op);
      return (op >= 4'h9) && (op <= 4'hE);
   endfunction

endpackage

// File: rtl/soat_mc_core_if.sv
// soat_mc_core_if: instruction and data memory request/ready ports of the core.
// Latency: n/a (wires only). master = core side, slave = memory side.
// Backpressure: a request is held until the matching ready is seen.
interface soat_mc_core_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_rdata;
   logic              imem_ready;
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic [DATA_W-1:0] dmem_rdata;
   logic              dmem_ready;

   modport master (
      output imem_req, imem_addr, input imem_rdata, imem_ready,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ready
   );

   modport slave (
      input  imem_req, imem_addr, output imem_rdata, imem_ready,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ready
   );
endinterface

// File: rtl/soat_regfile.sv
// soat_regfile: 8 x DATA_W register file, r0 reads as zero; ports: clk, reset,
// two async read ports (i_ra_addr/o_ra_dat, i_rb_addr/o_rb_dat), one sync write port (i_we/i_wa/i_wd).
// Latency: reads combinational, write visible the cycle after i_we. Backpressure: none.
module soat_regfile #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        i_ra_addr,
   output logic [DATA_W-1:0] o_ra_dat,
   input  logic [2:0]        i_rb_addr,
   output logic [DATA_W-1:0] o_rb_dat,
   input  logic              i_we,
   input  logic [2:0]        i_wa,
   input  logic [DATA_W-1:0] i_wd
);
   logic [DATA_W-1:0] r_regs [0:7];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) r_regs[i] <= '0;
      end else if (i_we && (i_wa != 3'd0)) begin
         r_regs[i_wa] <= i_wd;
      end
   end

   assign o_ra_dat = (i_ra_addr == 3'd0) ? '0 : r_regs[i_ra_addr];
   assign o_rb_dat = (i_rb_addr == 3'd0) ? '0 : r_regs[i_rb_addr];
endmodule

// File: rtl/soat_mc_core.sv
// soat_mc_core: multi-cycle SOAT CPU; ports: clk, reset, bus (imem/dmem request-ready), halted, illegal, pc.
// Latency: 3 (branch/jump), 4 (ALU/addi/jal/sw), 5 (lw), 2+DATA_W (mult) cycles at zero wait states.
// Backpressure: FETCH and MEM stall with request/address/data held until the port's ready.
module soat_mc_core
   import soat_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   soat_mc_core_if.master    bus,
   output logic              halted,
   output logic              illegal,
   output logic [ADDR_W-1:0] pc
);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [15:0]         r_ir;
   logic [DATA_W-1:0]   r_a, r_b, r_res, r_wdata, r_hi, r_lo, r_mplier;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_illegal;
   logic [2*DATA_W-1:0] r_mcand, r_acc;
   logic [CNT_W-1:0]    r_cnt;

   logic [3:0]          w_op;
   logic [2:0]          w_rs, w_rt, w_rd, w_fn, w_wa;
   logic [DATA_W-1:0]   w_imm, w_ra_dat, w_rb_dat, w_alu;
   logic [ADDR_W-1:0]   w_tgt, w_pc_inc, w_br_tgt;
   logic [2*DATA_W-1:0] w_acc_nxt;

   assign w_op  = r_ir[OP_MSB:OP_LSB];
   assign w_rs  = r_ir[RS_MSB:RS_LSB];
   assign w_rt  = r_ir[RT_MSB:RT_LSB];
   assign w_rd  = r_ir[RD_MSB:RD_LSB];
   assign w_fn  = r_ir[FN_MSB:FN_LSB];
   assign w_imm = DATA_W'($signed(r_ir[IMM_MSB:0]));
   assign w_tgt = ADDR_W'(r_ir[TGT_MSB:0]);

   assign w_pc_inc = r_pc + ADDR_W'(2);
   assign w_br_tgt = w_pc_inc + (w_imm[ADDR_W-1:0] << 1);

   // Destination: rd for R-type, r7 for jal, rt for addi/lw.
   assign w_wa = (w_op == OP_RTYPE) ? w_rd : ((w_op == OP_JAL) ? LINK_REG : w_rt);

   soat_regfile #(.DATA_W(DATA_W)) u_regfile (
      .clk       (clk),
      .reset     (reset),
      .i_ra_addr (w_rs),
      .o_ra_dat  (w_ra_dat),
      .i_rb_addr (w_rt),
      .o_rb_dat  (w_rb_dat),
      .i_we      (r_state == S_WB),
      .i_wa      (w_wa),
      .i_wd      (r_res)
   );

   always_comb begin
      w_alu = '0;
      case (w_op)
         OP_RTYPE: begin
            case (w_fn)
               FN_ADD:  w_alu = r_a + r_b;
               FN_SUB:  w_alu = r_a - r_b;
               FN_AND:  w_alu = r_a & r_b;
               FN_OR:   w_alu = r_a | r_b;
               FN_MFHI: w_alu = r_hi;
               FN_MFLO: w_alu = r_lo;
               FN_SLT:  w_alu = DATA_W'($signed(r_a) < $signed(r_b));
               default: w_alu = '0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: w_alu = r_a + w_imm;
         OP_JAL:  w_alu = DATA_W'(w_pc_inc);
         default: w_alu = '0;
      endcase
   end

   // Shift-add step: multiplicand moves left, multiplier right, one bit per cycle.
   assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_RST;
         r_pc      <= RESET_PC;
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_res     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_illegal <= 1'b0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            S_RST: r_state <= S_FETCH;
            S_FETCH: begin
               if (bus.imem_ready) begin
                  r_ir    <= bus.imem_rdata;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_a      <= w_ra_dat;
               r_b      <= w_rb_dat;
               r_mcand  <= {{DATA_W{1'b0}}, w_rb_dat};
               r_mplier <= w_ra_dat;
               r_acc    <= '0;
               r_cnt    <= '0;
               if (w_op == OP_HALT) begin
                  r_state <= S_HALT;
               end else if (is_illegal(w_op)) begin
                  r_illegal <= 1'b1;
                  r_state   <= S_HALT;
               end else if ((w_op == OP_RTYPE) && (w_fn == FN_MULT)) begin
                  r_state <= S_MULT;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_res   <= w_alu;
               r_addr  <= w_alu[ADDR_W-1:0];
               r_wdata <= r_b;
               r_pc    <= w_pc_inc;
               case (w_op)
                  OP_BEQ: begin
                     if (r_a == r_b) r_pc <= w_br_tgt;
                     r_state <= S_FETCH;
                  end
                  OP_BNE: begin
                     if (r_a != r_b) r_pc <= w_br_tgt;
                     r_state <= S_FETCH;
                  end
                  OP_J: begin
                     r_pc    <= w_tgt;
                     r_state <= S_FETCH;
                  end
                  OP_JAL: begin
                     r_pc    <= w_tgt;
                     r_state <= S_WB;
                  end
                  OP_JR: begin
                     r_pc    <= r_a[ADDR_W-1:0];
                     r_state <= S_FETCH;
                  end
                  OP_LW, OP_SW: r_state <= S_MEM;
                  default:      r_state <= S_WB;
               endcase
            end
            S_MEM: begin
               if (bus.dmem_ready) begin
                  r_res   <= bus.dmem_rdata;
                  r_state <= (w_op == OP_LW) ? S_WB : S_FETCH;
               end
            end
            S_WB: r_state <= S_FETCH;
            S_MULT: begin
               r_acc    <= w_acc_nxt;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               // HI/LO only change once the full product is known.
               if (r_cnt == CNT_W'(DATA_W - 1)) begin
                  {r_hi, r_lo} <= w_acc_nxt;
                  r_pc         <= w_pc_inc;
                  r_state      <= S_FETCH;
               end
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_RST;
         endcase
      end
   end

   // Outputs decode registered state only; address/data are zero outside their request.
   assign bus.imem_req   = (r_state == S_FETCH);
   assign bus.imem_addr  = (r_state == S_FETCH) ? r_pc : '0;
   assign bus.dmem_req   = (r_state == S_MEM);
   assign bus.dmem_we    = (r_state == S_MEM) && (w_op == OP_SW);
   assign bus.dmem_addr  = (r_state == S_MEM) ? r_addr : '0;
   assign bus.dmem_wdata = ((r_state == S_MEM) && (w_op == OP_SW)) ? r_wdata : '0;
   assign halted         = (r_state == S_HALT);
   assign illegal        = r_illegal;
   assign pc             = r_pc;
endmodule

// File: tb/tb_soat_mc_core.sv
`timescale 1ns/1ps
module tb_soat_mc_core;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   soat_mc_core_if #(.DATA_W(8), .ADDR_W(8)) bus ();
   logic       halted, illegal;
   logic [7:0] pc;

   soat_mc_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .halted  (halted),
      .illegal (illegal),
      .pc      (pc)
   );

   logic [15:0] prog [0:127];
   logic [7:0]  dmem [0:255];
   logic        iready = 1'b1;
   int          dwait = 0;
   int          dcnt = 0;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  f_addr [$];
   int          f_cyc  [$];
   logic [7:0]  s_addr [$];
   logic [7:0]  s_dat  [$];

   assign bus.imem_rdata = prog[bus.imem_addr[7:1]];
   assign bus.imem_ready = iready;
   assign bus.dmem_rdata = dmem[bus.dmem_addr];
   assign bus.dmem_ready = bus.dmem_req && (dcnt >= dwait);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.dmem_req && !bus.dmem_ready) dcnt <= dcnt + 1;
      else dcnt <= 0;
   end

   // Log handshakes that will complete on the coming rising edge.
   always @(negedge clk) begin
      if (!reset && bus.imem_req && bus.imem_ready) begin
         f_addr.push_back(bus.imem_addr);
         f_cyc.push_back(cyc);
      end
      if (!reset && bus.dmem_req && bus.dmem_we && bus.dmem_ready) begin
         dmem[bus.dmem_addr] = bus.dmem_wdata;
         s_addr.push_back(bus.dmem_addr);
         s_dat.push_back(bus.dmem_wdata);
      end
   end

   function automatic logic [15:0] enc_r(input int rs, input int rt, input int rd, input int fn);
      return {4'h0, 3'(rs), 3'(rt), 3'(rd), 3'(fn)};
   endfunction
   function automatic logic [15:0] enc_i(input logic [3:0] op, input int rs, input int rt, input logic [5:0] imm);
      return {op, 3'(rs), 3'(rt), imm};
   endfunction
   function automatic logic [15:0] enc_j(input logic [3:0] op, input logic [11:0] t);
      return {op, t};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_prog;
      for (int i = 0; i < 128; i++) prog[i] = 16'hF000;
      for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
   endtask

   task automatic clear_logs;
      f_addr.delete(); f_cyc.delete(); s_addr.delete(); s_dat.delete();
   endtask

   task automatic start(input int ws);
      reset = 1'b1;
      dwait = ws;
      tick(2);
      clear_logs();
      reset = 1'b0;
   endtask

   task automatic run_halt(input string name, input int max);
      int n = 0;
      while (!halted && n < max) begin
         tick(1);
         n++;
      end
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL %s_halt: halted=%b after %0d cycles, required 1", name, halted, max);
      end
   endtask

   task automatic test_reset;
      clear_prog();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.imem_req, bus.dmem_req, bus.dmem_we, halted, illegal} !== 5'b0 ||
             bus.imem_addr !== 8'h00 || bus.dmem_addr !== 8'h00 ||
             bus.dmem_wdata !== 8'h00 || pc !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs[%0d]: req=%b/%b we=%b halt=%b ill=%b ia=%h da=%h wd=%h pc=%h, required all 0",
                     i, bus.imem_req, bus.dmem_req, bus.dmem_we, halted, illegal,
                     bus.imem_addr, bus.dmem_addr, bus.dmem_wdata, pc);
         end
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_same_cycle: imem_req=%b, required 0", bus.imem_req);
      end
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
         errors++;
         $display("FAIL reset_first_fetch: imem_req=%b addr=%h, required 1 / 00", bus.imem_req, bus.imem_addr);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_alu;
      logic [7:0] ea [3] = '{8'h11, 8'h12, 8'h13};
      logic [7:0] ed [3] = '{8'h02, 8'h01, 8'h00};
      clear_prog();
      prog[0] = enc_i(4'h1, 0, 1, 6'd5);
      prog[1] = enc_i(4'h1, 0, 2, 6'h3D);
      prog[2] = enc_r(1, 2, 3, 0);
      prog[3] = enc_r(2, 1, 4, 7);
      prog[4] = enc_i(4'h1, 0, 0, 6'd7);
      prog[5] = enc_i(4'h3, 0, 3, 6'h11);
      prog[6] = enc_i(4'h3, 0, 4, 6'h12);
      prog[7] = enc_i(4'h3, 0, 0, 6'h13);
      start(0);
      run_halt("alu", 200);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= s_addr.size()) begin
            errors++;
            $display("FAIL alu_store[%0d]: missing, required addr=%h data=%h", i, ea[i], ed[i]);
         end else if (s_addr[i] !== ea[i] || s_dat[i] !== ed[i]) begin
            errors++;
            $display("FAIL alu_store[%0d]: addr=%h data=%h, required addr=%h data=%h",
                     i, s_addr[i], s_dat[i], ea[i], ed[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i + 1 >= f_cyc.size()) begin
            errors++;
            $display("FAIL alu_cycles[%0d]: fetch missing, required 4 cycles", i);
         end else if (f_cyc[i+1] - f_cyc[i] != 4) begin
            errors++;
            $display("FAIL alu_cycles[%0d]: %0d cycles, required 4", i, f_cyc[i+1] - f_cyc[i]);
         end
      end
      checks++;
      if (illegal !== 1'b0) begin
         errors++;
         $display("FAIL alu_halt_not_illegal: illegal=%b, required 0", illegal);
      end
   endtask

   task automatic test_mem_wait;
      int n = 0;
      int reqc = 0;
      clear_prog();
      prog[0] = enc_i(4'h1, 0, 3, 6'd2);
      prog[1] = enc_i(4'h3, 0, 3, 6'h10);
      prog[2] = enc_i(4'h2, 0, 5, 6'h10);
      prog[3] = enc_i(4'h3, 0, 5, 6'h14);
      start(3);
      while (!bus.dmem_req && n < 50) begin
         tick(1);
         n++;
      end
      while (bus.dmem_req && reqc < 20) begin
         checks++;
         if (bus.dmem_we !== 1'b1 || bus.dmem_addr !== 8'h10 || bus.dmem_wdata !== 8'h02) begin
            errors++;
            $display("FAIL mem_sw_stable[%0d]: we=%b addr=%h wdata=%h, required 1/10/02",
                     reqc, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata);
         end
         reqc++;
         tick(1);
      end
      checks++;
      if (reqc != 4) begin
         errors++;
         $display("FAIL mem_sw_req_len: %0d cycles, required 4", reqc);
      end
      run_halt("mem", 200);
      checks++;
      if (s_addr.size() != 2) begin
         errors++;
         $display("FAIL mem_store_count: %0d, required 2", s_addr.size());
      end else if (s_addr[0] !== 8'h10 || s_dat[0] !== 8'h02 || s_addr[1] !== 8'h14 || s_dat[1] !== 8'h02) begin
         errors++;
         $display("FAIL mem_store_vals: %h:%h %h:%h, required 10:02 14:02", s_addr[0], s_dat[0], s_addr[1], s_dat[1]);
      end
      checks++;
      if (f_cyc.size() < 4) begin
         errors++;
         $display("FAIL mem_cycles: %0d fetches, required at least 4", f_cyc.size());
      end else if (f_cyc[2] - f_cyc[1] != 7 || f_cyc[3] - f_cyc[2] != 8) begin
         errors++;
         $display("FAIL mem_cycles: sw=%0d lw=%0d, required sw=7 lw=8", f_cyc[2] - f_cyc[1], f_cyc[3] - f_cyc[2]);
      end
   endtask

   task automatic test_mult;
      clear_prog();
      prog[0] = enc_i(4'h1, 0, 1, 6'h3F);
      prog[1] = enc_r(1, 1, 0, 6);
      prog[2] = enc_r(0, 0, 6, 4);
      prog[3] = enc_r(0, 0, 7, 5);
      prog[4] = enc_i(4'h3, 0, 6, 6'h18);
      prog[5] = enc_i(4'h3, 0, 7, 6'h19);
      start(0);
      run_halt("mult", 200);
      checks++;
      if (f_cyc.size() < 3) begin
         errors++;
         $display("FAIL mult_cycles: %0d fetches, required at least 3", f_cyc.size());
      end else if (f_cyc[2] - f_cyc[1] != 10) begin
         errors++;
         $display("FAIL mult_cycles: %0d cycles, required 10", f_cyc[2] - f_cyc[1]);
      end
      checks++;
      if (s_addr.size() != 2) begin
         errors++;
         $display("FAIL mult_store_count: %0d, required 2", s_addr.size());
      end else if (s_addr[0] !== 8'h18 || s_dat[0] !== 8'hFE || s_addr[1] !== 8'h19 || s_dat[1] !== 8'h01) begin
         errors++;
         $display("FAIL mult_hi_lo: %h:%h %h:%h, required 18:FE 19:01", s_addr[0], s_dat[0], s_addr[1], s_dat[1]);
      end
   endtask

   task automatic test_control;
      logic [7:0] ea [7] = '{8'h00, 8'h20, 8'h40, 8'h42, 8'h22, 8'h22, 8'h22};
      int         ed [6] = '{3, 4, 4, 3, 3, 3};
      clear_prog();
      prog[0]  = enc_j(4'h6, 12'h020);
      prog[16] = enc_j(4'h7, 12'h040);
      prog[32] = enc_i(4'h3, 0, 7, 6'h1A);
      prog[33] = enc_i(4'h8, 7, 0, 6'h00);
      prog[17] = enc_i(4'h5, 0, 7, 6'h3F);
      start(0);
      tick(40);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (i >= f_addr.size()) begin
            errors++;
            $display("FAIL ctl_fetch[%0d]: missing, required %h", i, ea[i]);
         end else if (f_addr[i] !== ea[i] || (i > 0 && f_cyc[i] - f_cyc[i-1] != ed[i-1])) begin
            errors++;
            $display("FAIL ctl_fetch[%0d]: addr=%h, required %h (interval required %0d)",
                     i, f_addr[i], ea[i], (i > 0) ? ed[i-1] : 0);
         end
      end
      checks++;
      if (s_addr.size() != 1 || s_addr[0] !== 8'h1A || s_dat[0] !== 8'h22) begin
         errors++;
         $display("FAIL ctl_link: %0d stores, first=%h:%h, required 1 store 1A:22",
                  s_addr.size(), (s_addr.size() > 0) ? s_addr[0] : 8'hXX, (s_dat.size() > 0) ? s_dat[0] : 8'hXX);
      end
      checks++;
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL ctl_loop_running: halted=%b, required 0", halted);
      end
   endtask

   task automatic test_beq;
      clear_prog();
      prog[0] = enc_i(4'h1, 0, 1, 6'd1);
      prog[1] = enc_i(4'h4, 0, 1, 6'd5);
      prog[2] = enc_i(4'h4, 0, 0, 6'd3);
      start(0);
      run_halt("beq", 100);
      checks++;
      if (f_addr.size() != 4 || f_addr[2] !== 8'h04 || f_addr[3] !== 8'h0C) begin
         errors++;
         $display("FAIL beq_flow: %0d fetches, 3rd=%h 4th=%h, required 4 fetches 04 then 0C",
                  f_addr.size(), (f_addr.size() > 2) ? f_addr[2] : 8'hXX, (f_addr.size() > 3) ? f_addr[3] : 8'hXX);
      end
   endtask

   task automatic test_illegal;
      int reqs = 0;
      clear_prog();
      prog[0] = enc_i(4'h1, 0, 1, 6'd1);
      prog[1] = 16'hE000;
      start(0);
      run_halt("illegal", 100);
      checks++;
      if (illegal !== 1'b1) begin
         errors++;
         $display("FAIL illegal_flag: illegal=%b, required 1", illegal);
      end
      for (int i = 0; i < 20; i++) begin
         if (bus.imem_req || bus.dmem_req) reqs++;
         tick(1);
      end
      checks++;
      if (reqs != 0) begin
         errors++;
         $display("FAIL illegal_quiet: %0d request cycles, required 0", reqs);
      end
      reset = 1'b1;
      tick(1);
      checks++;
      if (halted !== 1'b0 || illegal !== 1'b0 || bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL illegal_reset: halted=%b illegal=%b imem_req=%b, required 0/0/0",
                  halted, illegal, bus.imem_req);
      end
      reset = 1'b0;
   endtask

   task automatic test_abort;
      int n = 0;
      clear_prog();
      prog[0] = enc_i(4'h1, 0, 3, 6'd9);
      prog[1] = enc_i(4'h3, 0, 3, 6'h10);
      start(100);
      while (!bus.dmem_req && n < 50) begin
         tick(1);
         n++;
      end
      tick(1);
      checks++;
      if (bus.dmem_req !== 1'b1) begin
         errors++;
         $display("FAIL abort_in_mem: dmem_req=%b, required 1", bus.dmem_req);
      end
      reset = 1'b1;
      tick(1);
      checks++;
      if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || pc !== 8'h00) begin
         errors++;
         $display("FAIL abort_reset: dmem_req=%b we=%b pc=%h, required 0/0/00", bus.dmem_req, bus.dmem_we, pc);
      end
      clear_prog();
      prog[0] = enc_i(4'h3, 0, 3, 6'h11);
      dwait = 0;
      clear_logs();
      reset = 1'b0;
      tick(1);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
         errors++;
         $display("FAIL abort_restart: imem_req=%b addr=%h, required 1/00", bus.imem_req, bus.imem_addr);
      end
      run_halt("abort", 100);
      checks++;
      if (s_addr.size() != 1 || s_addr[0] !== 8'h11 || s_dat[0] !== 8'h00) begin
         errors++;
         $display("FAIL abort_regs_cleared: %0d stores, first=%h:%h, required 1 store 11:00",
                  s_addr.size(), (s_addr.size() > 0) ? s_addr[0] : 8'hXX, (s_dat.size() > 0) ? s_dat[0] : 8'hXX);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem_wait();
      test_mult();
      test_control();
      test_beq();
      test_illegal();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
